mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder_if.sv | 18 +
 rtl/mem_io_responder.sv | 114 +++++++++++
 tb/tb_mem_io_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// ============================================================================
// Module : mem_io_responder_if
// Brief  : Processor memory bus (address, write data/enable, read data).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_io_responder_if;
   logic [15:0] address;
   logic [15:0] D_out;
   logic        mw_en;
   logic [15:0] D_in;

   modport master (output address, output D_out, output mw_en, input D_in);
   modport slave  (input address, input D_out, input mw_en, output D_in);
endinterface

`default_nettype wire

// File: rtl/mem_io_responder.sv
// ============================================================================
// Module : mem_io_responder
// Brief  : Zero-wait-state RAM plus memory-mapped I/O page (out, switches, timer, status, write counter).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_io_responder #(
   parameter int RAM_AW = 8
) (
   input  logic                clk,
   input  logic                reset,
   mem_io_responder_if.slave   bus,
   input  logic [7:0]          status,
   input  logic [15:0]         sw_in,
   output logic [15:0]         out_reg,
   output logic                tmr_irq
);

   localparam int          C_RAM_WORDS = 1 << RAM_AW;
   localparam logic [15:0] C_IO_OUT    = 16'hFF00;
   localparam logic [15:0] C_IO_SW     = 16'hFF01;
   localparam logic [15:0] C_IO_TCNT   = 16'hFF02;
   localparam logic [15:0] C_IO_TCMP   = 16'hFF03;
   localparam logic [15:0] C_IO_TFLAG  = 16'hFF04;
   localparam logic [15:0] C_IO_STAT   = 16'hFF05;
   localparam logic [15:0] C_IO_WCNT   = 16'hFF06;

   logic [15:0]       r_ram [C_RAM_WORDS];
   logic [15:0]       r_out;
   logic [15:0]       r_tcnt;
   logic [15:0]       r_tcmp;
   logic              r_tflag;
   logic [15:0]       r_sw_meta;
   logic [15:0]       r_sw_sync;
   logic [7:0]        r_stat;
   logic [15:0]       r_wcnt;

   logic              w_ram_sel;
   logic [RAM_AW-1:0] w_ram_idx;
   logic              w_wr;
   logic              w_match;
   logic [15:0]       w_rd_data;

   assign w_ram_sel = (bus.address[15:RAM_AW] == '0);
   assign w_ram_idx = bus.address[RAM_AW-1:0];
   // Writes are gated by reset so the RAM (which has no reset) cannot be corrupted while reset is held.
   assign w_wr      = bus.mw_en & ~reset;
   assign w_match   = (r_tcnt == r_tcmp);

   always_ff @(posedge clk) begin
      if (w_wr && w_ram_sel) begin
         r_ram[w_ram_idx] <= bus.D_out;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out     <= 16'h0000;
         r_tcnt    <= 16'h0000;
         r_tcmp    <= 16'hFFFF;
         r_tflag   <= 1'b0;
         r_sw_meta <= 16'h0000;
         r_sw_sync <= 16'h0000;
         r_stat    <= 8'h00;
         r_wcnt    <= 16'h0000;
      end else begin
         r_sw_meta <= sw_in;
         r_sw_sync <= r_sw_meta;
         r_stat    <= status;
         r_tcnt    <= r_tcnt + 16'd1;
         if (w_wr && bus.address == C_IO_OUT) begin
            r_out <= bus.D_out;
         end
         if (w_wr && bus.address == C_IO_TCMP) begin
            r_tcmp <= bus.D_out;
         end
         // A match always wins over a coincident write-1-to-clear.
         if (w_match) begin
            r_tflag <= 1'b1;
         end else if (w_wr && bus.address == C_IO_TFLAG && bus.D_out[0]) begin
            r_tflag <= 1'b0;
         end
         if (w_wr && r_wcnt != 16'hFFFF) begin
            r_wcnt <= r_wcnt + 16'd1;
         end
      end
   end

   always_comb begin
      w_rd_data = 16'h0000;
      if (w_ram_sel) begin
         w_rd_data = r_ram[w_ram_idx];
      end else begin
         case (bus.address)
            C_IO_OUT:   w_rd_data = r_out;
            C_IO_SW:    w_rd_data = r_sw_sync;
            C_IO_TCNT:  w_rd_data = r_tcnt;
            C_IO_TCMP:  w_rd_data = r_tcmp;
            C_IO_TFLAG: w_rd_data = {15'b0, r_tflag};
            C_IO_STAT:  w_rd_data = {8'h00, r_stat};
            C_IO_WCNT:  w_rd_data = r_wcnt;
            default:    w_rd_data = 16'h0000;
         endcase
      end
   end

   assign bus.D_in = w_rd_data;
   assign out_reg  = r_out;
   assign tmr_irq  = r_tflag;

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// ============================================================================
// Module : tb_mem_io_responder
// Brief  : Self-checking bench for mem_io_responder (vector table + scoreboard).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_io_responder;

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic [7:0]  status = 8'h00;
   logic [15:0] sw_in  = 16'h0000;
   wire  [15:0] out_reg;
   wire         tmr_irq;

   mem_io_responder_if bus_if ();

   mem_io_responder #(.RAM_AW(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus_if),
      .status  (status),
      .sw_in   (sw_in),
      .out_reg (out_reg),
      .tmr_irq (tmr_irq)
   );

   always #5 clk = ~clk;

   // Reference timer: free-running counter cleared asynchronously by reset.
   logic [15:0] tcnt_m;
   always @(posedge clk or posedge reset) begin
      if (reset) tcnt_m <= 16'h0000;
      else       tcnt_m <= tcnt_m + 16'd1;
   end

   typedef struct {
      logic        we;
      logic [15:0] waddr;
      logic [15:0] wdata;
      logic [15:0] raddr;
      logic [15:0] exp;
      string       nm;
   } vec_t;

   typedef struct {
      string       nm;
      logic [15:0] exp;
   } sb_t;

   sb_t  sbq[$];
   vec_t vecs[9];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
      bus_if.address = a;
      bus_if.D_out   = d;
      bus_if.mw_en   = 1'b1;
      @(posedge clk); #1;
      bus_if.mw_en   = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] e, input string nm);
      sb_t s;
      bus_if.address = a;
      bus_if.mw_en   = 1'b0;
      sbq.push_back('{nm: nm, exp: e});
      @(negedge clk);
      s = sbq.pop_front();
      chk(s.nm, bus_if.D_in, s.exp);
      @(posedge clk); #1;
   endtask

   task automatic peek(input logic [15:0] a, input logic [15:0] e, input string nm);
      bus_if.address = a;
      #1;
      chk(nm, bus_if.D_in, e);
   endtask

   task automatic wait_tcnt(input logic [15:0] t);
      int n = 0;
      while (tcnt_m != t && n < 70000) begin
         @(posedge clk); #1;
         n++;
      end
      if (tcnt_m != t) chk("tcnt_wait_timeout", tcnt_m, t);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      int errs  = 0;
      int zeros = 0;

      vecs[0] = '{1'b1, 16'h0005, 16'h1234, 16'h0005, 16'h1234, "ram_wr_rd"};
      vecs[1] = '{1'b0, 16'h0000, 16'h0000, 16'h0105, 16'h0000, "unmapped_0105"};
      vecs[2] = '{1'b1, 16'h00FF, 16'hBEEF, 16'h00FF, 16'hBEEF, "ram_top_word"};
      vecs[3] = '{1'b1, 16'h0000, 16'h1111, 16'h0000, 16'h1111, "ram_word0"};
      vecs[4] = '{1'b1, 16'h1000, 16'hDEAD, 16'h0000, 16'h1111, "no_alias_wr"};
      vecs[5] = '{1'b1, 16'hFF07, 16'h5555, 16'hFF07, 16'h0000, "io_unmapped"};
      vecs[6] = '{1'b1, 16'hFF00, 16'hA5A5, 16'hFF00, 16'hA5A5, "out_rd"};
      vecs[7] = '{1'b1, 16'hFF05, 16'hFFFF, 16'hFF05, 16'h0000, "stat_ro"};
      vecs[8] = '{1'b1, 16'hFF03, 16'h0040, 16'hFF03, 16'h0040, "tcmp_rd"};

      bus_if.address = 16'h0000;
      bus_if.D_out   = 16'h0000;
      bus_if.mw_en   = 1'b0;

      // Values while reset is held
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_reg", out_reg, 16'h0000);
      chk("rst_irq", {15'b0, tmr_irq}, 16'h0000);
      peek(16'hFF03, 16'hFFFF, "rst_tcmp");
      peek(16'hFF02, 16'h0000, "rst_tcnt");
      peek(16'hFF06, 16'h0000, "rst_wcnt");
      reset = 1'b0;

      foreach (vecs[i]) begin
         if (vecs[i].we) bus_write(vecs[i].waddr, vecs[i].wdata);
         rd(vecs[i].raddr, vecs[i].exp, vecs[i].nm);
      end
      chk("out_reg_port", out_reg, 16'hA5A5);

      bus_write(16'hFF02, 16'h1234);
      rd(16'hFF02, tcnt_m, "tcnt_ro");

      // Timer match and flag behaviour
      pulse_reset();
      bus_write(16'hFF03, 16'h0010);
      wait_tcnt(16'h0010);
      @(negedge clk);
      chk("irq_at_match", {15'b0, tmr_irq}, 16'h0000);
      @(posedge clk); #1;
      @(negedge clk);
      chk("irq_after_match", {15'b0, tmr_irq}, 16'h0001);
      @(posedge clk); #1;
      rd(16'hFF04, 16'h0001, "tflag_rd");
      bus_write(16'hFF03, 16'h0040);
      wait_tcnt(16'h0040);
      bus_write(16'hFF04, 16'h0001);
      @(negedge clk);
      chk("set_beats_clear", {15'b0, tmr_irq}, 16'h0001);
      bus_write(16'hFF04, 16'hFFFE);
      @(negedge clk);
      chk("write0_keeps", {15'b0, tmr_irq}, 16'h0001);
      bus_write(16'hFF04, 16'h0001);
      @(negedge clk);
      chk("w1c_clears", {15'b0, tmr_irq}, 16'h0000);
      rd(16'hFF04, 16'h0000, "tflag_rd_clr");

      // Switch synchroniser: two edges of latency
      sw_in = 16'h00FF;
      bus_if.address = 16'hFF01;
      @(negedge clk);
      chk("sw_edge0", bus_if.D_in, 16'h0000);
      @(posedge clk); #1;
      @(negedge clk);
      chk("sw_edge1", bus_if.D_in, 16'h0000);
      @(posedge clk); #1;
      @(negedge clk);
      chk("sw_edge2", bus_if.D_in, 16'h00FF);
      @(posedge clk); #1;

      status = 8'h5A;
      bus_if.address = 16'hFF05;
      @(negedge clk);
      chk("stat_edge0", bus_if.D_in, 16'h0000);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stat_edge1", bus_if.D_in, 16'h005A);
      @(posedge clk); #1;

      // Long write burst to the read-only TCNT register
      bus_if.address = 16'hFF02;
      bus_if.mw_en   = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         bus_if.D_out = 16'($urandom);
         @(negedge clk);
         if (bus_if.D_in !== tcnt_m) errs++;
         if (bus_if.D_in == 16'h0000) zeros++;
         @(posedge clk); #1;
      end
      bus_if.mw_en = 1'b0;
      chk("hold_tcnt_errs", 16'(errs), 16'h0000);
      chk("tcnt_wrapped", {15'b0, (zeros != 0)}, 16'h0001);
      rd(16'hFF06, 16'hFFFF, "wcnt_sat");
      bus_write(16'h8000, 16'h0000);
      rd(16'hFF06, 16'hFFFF, "wcnt_stays");

      // Reset in the middle of a run
      bus_write(16'hFF00, 16'h3C3C);
      @(negedge clk);
      chk("out_pre_reset", out_reg, 16'h3C3C);
      chk("irq_pre_reset", {15'b0, tmr_irq}, 16'h0001);
      reset = 1'b1;
      #1;
      chk("midrst_out", out_reg, 16'h0000);
      chk("midrst_irq", {15'b0, tmr_irq}, 16'h0000);
      peek(16'hFF02, 16'h0000, "midrst_tcnt");
      peek(16'hFF06, 16'h0000, "midrst_wcnt");
      peek(16'hFF03, 16'hFFFF, "midrst_tcmp");
      peek(16'h0005, 16'h1234, "midrst_ram");
      bus_if.address = 16'h0005;
      bus_if.D_out   = 16'hBEEF;
      bus_if.mw_en   = 1'b1;
      @(posedge clk); #1;
      bus_if.mw_en   = 1'b0;
      reset = 1'b0;
      rd(16'h0005, 16'h1234, "ram_kept_wr_in_rst");
      rd(16'hFF06, 16'h0000, "wcnt_no_rst_wr");
      bus_write(16'h0005, 16'h4321);
      rd(16'h0005, 16'h4321, "first_wr_after_rst");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire
